// File: rtl/row_chunk_issuer.sv
// Walks an N x N matrix row by row in NI-lane chunks, issuing matrix/vector
// reads and presenting aligned operand pairs to the multiplier array.
// Ports: clk, rst_n (async low), go; mat_/vec_ rd_en, addr, data;
// prod_a/prod_b operand buses, lane_valid, row_last, start_out, busy, done.
module row_chunk_issuer #(
  parameter int NI     = 8,
  parameter int N      = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  output logic              mat_rd_en,
  output logic [ADDR_W-1:0] mat_addr,
  input  logic [NI*32-1:0]  mat_data,
  output logic              vec_rd_en,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [NI*32-1:0]  vec_data,
  output logic [NI*32-1:0]  prod_a,
  output logic [NI*32-1:0]  prod_b,
  output logic              lane_valid,
  output logic              row_last,
  output logic              start_out,
  output logic              busy,
  output logic              done
);

  localparam int C  = N / NI;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(C - 1);
  localparam logic [RW-1:0] R_LAST = RW'(N - 1);

  generate
    if (N % NI != 0) begin : g_bad_dim
      $error("row_chunk_issuer: N must be a multiple of NI");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_chunk;
  logic [RW-1:0]     r_row;
  logic              r_flush;
  logic              r_go_q;
  logic              r_v1;
  logic              r_last1;
  logic              r_valid;
  logic              r_rlast;
  logic              r_start;
  logic [NI*32-1:0]  r_a;
  logic [NI*32-1:0]  r_b;

  logic w_go_rise;
  logic w_issue;
  logic w_chunk_last;
  logic w_row_last;

  // A pass starts only on a rising edge of go seen in IDLE, so a level
  // held high (or raised while busy) never chains extra passes.
  assign w_go_rise    = go & ~r_go_q;
  assign w_issue      = (r_state == S_RUN);
  assign w_chunk_last = (r_chunk == C_LAST);
  assign w_row_last   = (r_row == R_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_go_rise) w_next = S_RUN;
      S_RUN:   if (w_chunk_last && w_row_last) w_next = S_FLUSH;
      S_FLUSH: if (r_flush) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_chunk <= '0;
      r_row   <= '0;
      r_flush <= 1'b0;
      r_go_q  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_go_q  <= go;
      r_flush <= (r_state == S_FLUSH) ? ~r_flush : 1'b0;
      if (w_issue) begin
        if (w_chunk_last) begin
          r_chunk <= '0;
          r_row   <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_chunk <= r_chunk + 1'b1;
        end
      end
    end
  end

  // Stage 1 tracks the address in flight; stage 2 registers memory data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_valid <= 1'b0;
      r_rlast <= 1'b0;
      r_start <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_v1    <= w_issue;
      r_last1 <= w_issue & w_chunk_last;
      r_valid <= r_v1;
      r_rlast <= r_v1 & r_last1;
      if (w_next == S_IDLE) r_start <= 1'b0;
      else if (r_v1)        r_start <= 1'b1;
      if (r_v1) begin
        r_a <= mat_data;
        r_b <= vec_data;
      end
    end
  end

  assign mat_rd_en  = w_issue;
  assign vec_rd_en  = w_issue;
  assign mat_addr   = w_issue ?
    (ADDR_W'(r_row) * ADDR_W'(C) + ADDR_W'(r_chunk)) : '0;
  assign vec_addr   = w_issue ? ADDR_W'(r_chunk) : '0;
  assign prod_a     = r_a;
  assign prod_b     = r_b;
  assign lane_valid = r_valid;
  assign row_last   = r_rlast;
  assign start_out  = r_start;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_row_chunk_issuer.sv
// Bench for row_chunk_issuer: N=16 and N=8 instances with tagged-word
// memory models; table-driven pass checks plus corner-case sequences.
module tb_row_chunk_issuer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, go, go8;

  logic         m_en, v_en, lv, rl, st, bz, dn;
  logic [15:0]  m_addr, v_addr;
  logic [255:0] m_data = '0, v_data = '0, pa, pb;

  logic         m_en8, v_en8, lv8, rl8, st8, bz8, dn8;
  logic [15:0]  m_addr8, v_addr8;
  logic [255:0] m_data8 = '0, v_data8 = '0, pa8, pb8;

  row_chunk_issuer #(.NI(8), .N(16), .ADDR_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .go(go),
    .mat_rd_en(m_en), .mat_addr(m_addr), .mat_data(m_data),
    .vec_rd_en(v_en), .vec_addr(v_addr), .vec_data(v_data),
    .prod_a(pa), .prod_b(pb), .lane_valid(lv), .row_last(rl),
    .start_out(st), .busy(bz), .done(dn)
  );

  row_chunk_issuer #(.NI(8), .N(8), .ADDR_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .go(go8),
    .mat_rd_en(m_en8), .mat_addr(m_addr8), .mat_data(m_data8),
    .vec_rd_en(v_en8), .vec_addr(v_addr8), .vec_data(v_data8),
    .prod_a(pa8), .prod_b(pb8), .lane_valid(lv8), .row_last(rl8),
    .start_out(st8), .busy(bz8), .done(dn8)
  );

  function automatic logic [255:0] mat_word(int a);
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = {16'(a), 16'(i)};
    return w;
  endfunction

  function automatic logic [255:0] vec_word(int c);
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = {16'(c + 256), 16'(i)};
    return w;
  endfunction

  always @(posedge clk) begin
    if (m_en)  m_data  <= mat_word(int'(m_addr));
    if (v_en)  v_data  <= vec_word(int'(v_addr));
    if (m_en8) m_data8 <= mat_word(int'(m_addr8));
    if (v_en8) v_data8 <= vec_word(int'(v_addr8));
  end

  int nv16 = 0, nd16 = 0, nv8 = 0, nrl8 = 0, nbadv8 = 0;
  always @(posedge clk) begin
    if (lv)          nv16   <= nv16 + 1;
    if (dn)          nd16   <= nd16 + 1;
    if (lv8)         nv8    <= nv8 + 1;
    if (lv8 && rl8)  nrl8   <= nrl8 + 1;
    if (v_en8 && v_addr8 != 16'd0) nbadv8 <= nbadv8 + 1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         en;
    logic [15:0]  ma;
    logic [15:0]  va;
    logic         lv, rl, st, bz, dn, dchk;
    logic [255:0] a, b;
  } vec_t;

  localparam int NK = 37;
  vec_t tbl[NK];

  // Expected per-cycle outputs of one N=16 pass; index k = after edge Ek.
  task automatic fill_table();
    for (int k = 0; k < NK; k++) begin
      int j;
      tbl[k].en   = (k <= 31);
      tbl[k].ma   = tbl[k].en ? 16'(k) : 16'd0;
      tbl[k].va   = tbl[k].en ? 16'(k % 2) : 16'd0;
      tbl[k].lv   = (k >= 2 && k <= 33);
      tbl[k].rl   = tbl[k].lv && ((k - 2) % 2 == 1);
      tbl[k].st   = (k >= 2 && k <= 34);
      tbl[k].bz   = (k <= 34);
      tbl[k].dn   = (k == 34);
      tbl[k].dchk = (k >= 2);
      j = (k > 33) ? 31 : k - 2;
      tbl[k].a    = mat_word(j);
      tbl[k].b    = vec_word(j % 2);
    end
  endtask

  task automatic run_table(string tag);
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("%s k%0d mat_rd_en", tag, k), 256'(m_en), 256'(tbl[k].en));
      chk($sformatf("%s k%0d vec_rd_en", tag, k), 256'(v_en), 256'(tbl[k].en));
      chk($sformatf("%s k%0d mat_addr", tag, k), 256'(m_addr), 256'(tbl[k].ma));
      chk($sformatf("%s k%0d vec_addr", tag, k), 256'(v_addr), 256'(tbl[k].va));
      chk($sformatf("%s k%0d lane_valid", tag, k), 256'(lv), 256'(tbl[k].lv));
      chk($sformatf("%s k%0d row_last", tag, k), 256'(lv & rl), 256'(tbl[k].rl));
      chk($sformatf("%s k%0d start_out", tag, k), 256'(st), 256'(tbl[k].st));
      chk($sformatf("%s k%0d busy", tag, k), 256'(bz), 256'(tbl[k].bz));
      chk($sformatf("%s k%0d done", tag, k), 256'(dn), 256'(tbl[k].dn));
      if (tbl[k].dchk) begin
        chk($sformatf("%s k%0d prod_a", tag, k), pa, tbl[k].a);
        chk($sformatf("%s k%0d prod_b", tag, k), pb, tbl[k].b);
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " mat_rd_en"}, 256'(m_en), 256'd0);
    chk({tag, " mat_addr"}, 256'(m_addr), 256'd0);
    chk({tag, " vec_rd_en"}, 256'(v_en), 256'd0);
    chk({tag, " vec_addr"}, 256'(v_addr), 256'd0);
    chk({tag, " prod_a"}, pa, 256'd0);
    chk({tag, " prod_b"}, pb, 256'd0);
    chk({tag, " lane_valid"}, 256'(lv), 256'd0);
    chk({tag, " row_last"}, 256'(rl), 256'd0);
    chk({tag, " start_out"}, 256'(st), 256'd0);
    chk({tag, " busy"}, 256'(bz), 256'd0);
    chk({tag, " done"}, 256'(dn), 256'd0);
  endtask

  initial begin
    int bv, bd, brl, bb;
    rst_n = 1'b0;
    go    = 1'b0;
    go8   = 1'b0;
    fill_table();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_table("pass1");

    // go held high: one pass only
    bv = nv16; bd = nd16;
    go = 1'b1;
    repeat (100) @(negedge clk);
    go = 1'b0;
    repeat (10) @(negedge clk);
    chk("held valids", 256'(nv16 - bv), 256'd32);
    chk("held dones", 256'(nd16 - bd), 256'd1);

    run_table("pass2");

    // go pulses during RUN and during DONE are ignored
    bv = nv16; bd = nd16;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    repeat (5) @(negedge clk);
    go = 1'b1;
    @(negedge clk) go = 1'b0;
    repeat (28) @(negedge clk);
    chk("ign done cycle", 256'(dn), 256'd1);
    go = 1'b1;
    @(negedge clk) go = 1'b0;
    chk("ign idle after done", 256'(bz), 256'd0);
    repeat (40) @(negedge clk);
    chk("ign valids", 256'(nv16 - bv), 256'd32);
    chk("ign dones", 256'(nd16 - bd), 256'd1);
    chk("ign busy", 256'(bz), 256'd0);

    // asynchronous reset mid-pass
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrst busy before", 256'(bz), 256'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_table("pass3");

    // N == NI: single chunk per row
    bv = nv8; brl = nrl8; bb = nbadv8;
    @(negedge clk) go8 = 1'b1;
    @(negedge clk) go8 = 1'b0;
    repeat (30) @(negedge clk);
    chk("n8 valids", 256'(nv8 - bv), 256'd8);
    chk("n8 row_last", 256'(nrl8 - brl), 256'd8);
    chk("n8 vec_addr", 256'(nbadv8 - bb), 256'd0);
    chk("n8 busy", 256'(bz8), 256'd0);
    chk("n8 prod_a hold", pa8, mat_word(7));
    chk("n8 prod_b hold", pb8, vec_word(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
